// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared parameters and FSM state type for the SID write scheduler
package sid_pkg;

   localparam int SID_NUM_REGS   = 25;
   localparam int SID_ADDR_BITS  = 5;
   localparam int SID_RST_CYCLES = 10;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ALIGN  = 2'd2,
      ST_STROBE = 2'd3
   } sid_state_e;

endpackage

// File: rtl/sid_prio_enc.sv
// rtl/sid_prio_enc.sv - lowest-set-bit encoder over the pending register set
module sid_prio_enc
   import sid_pkg::*;
#(
   parameter int NUM_REGS  = SID_NUM_REGS,
   parameter int ADDR_BITS = SID_ADDR_BITS
) (
   input  logic [NUM_REGS-1:0]  pending_i,
   output logic [ADDR_BITS-1:0] idx_o,
   output logic                 valid_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      idx_o   = '0;
      valid_o = |pending_i;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (pending_i[i]) begin
            idx_o = ADDR_BITS'(i);
         end
      end
   end

endmodule

// File: rtl/sid_write_sched.sv
// rtl/sid_write_sched.sv - streams changed SID registers to the chip, one write per phi2 period
module sid_write_sched
   import sid_pkg::*;
#(
   parameter int NUM_REGS   = SID_NUM_REGS,
   parameter int ADDR_BITS  = SID_ADDR_BITS,
   parameter int RST_CYCLES = SID_RST_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sid_clk,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic                 commit,
   input  logic                 sid_reset_req,
   output logic [ADDR_BITS-1:0] rd_addr,
   output logic                 bus_oe,
   output logic                 sid_cs_n,
   output logic                 sid_rw,
   output logic                 sid_rst_n,
   output logic                 busy,
   output logic                 overrun
);

   localparam int CNT_W = $clog2(RST_CYCLES + 1);
   localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

   sid_state_e           state_q, state_d;
   logic                 sid_clk_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_REGS-1:0]  dirty_q, dirty_d;
   logic [NUM_REGS-1:0]  pending_q, pending_d;
   logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
   logic                 cs_n_q, cs_n_d;
   logic                 rw_q, rw_d;
   logic                 srst_n_q, srst_n_d;
   logic                 oe_q, oe_d;
   logic                 busy_q, busy_d;
   logic                 overrun_q, overrun_d;

   logic                 phi2_rise;
   logic                 phi2_fall;
   logic [NUM_REGS-1:0]  wr_mask;
   logic [NUM_REGS-1:0]  clr_mask;
   logic [ADDR_BITS-1:0] enc_idx;
   logic                 enc_valid;

   assign phi2_rise = sid_clk & ~sid_clk_q;
   assign phi2_fall = ~sid_clk & sid_clk_q;

   sid_prio_enc #(
      .NUM_REGS  (NUM_REGS),
      .ADDR_BITS (ADDR_BITS)
   ) u_prio_enc (
      .pending_i (pending_q),
      .idx_o     (enc_idx),
      .valid_o   (enc_valid)
   );

   // Decode the SPI write strobe into a one-hot mark; out-of-range addresses are dropped.
   always_comb begin
      wr_mask = '0;
      if (wr_en && (32'(wr_addr) < NUM_REGS)) begin
         wr_mask = ONE_HOT0 << wr_addr;
      end
   end

   // Sequencer: reset timing, register selection and chip-select strobing, plus set bookkeeping.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_addr_d = rd_addr_q;
      cs_n_d    = cs_n_q;
      rw_d      = rw_q;
      srst_n_d  = srst_n_q;
      oe_d      = oe_q;
      clr_mask  = '0;

      case (state_q)
         ST_RESET: begin
            cs_n_d   = 1'b1;
            rw_d     = 1'b1;
            oe_d     = 1'b0;
            srst_n_d = 1'b0;
            if (phi2_fall) begin
               if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                  cnt_d    = '0;
                  srst_n_d = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_IDLE: begin
            // Bus stays driven for one clk after cs_n rises so data hold is met.
            cs_n_d = 1'b1;
            rw_d   = 1'b1;
            oe_d   = 1'b0;
            if (enc_valid) begin
               rd_addr_d = enc_idx;
               oe_d      = 1'b1;
               rw_d      = 1'b0;
               state_d   = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            if (phi2_rise) begin
               cs_n_d  = 1'b0;
               state_d = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (phi2_fall) begin
               cs_n_d   = 1'b1;
               rw_d     = 1'b1;
               clr_mask = ONE_HOT0 << rd_addr_q;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase

      // A commit moves the finished frame into the pending set; writes in the same clk
      // belong to the next frame. Clearing the strobed bit first lets a re-commit re-arm it.
      dirty_d   = (commit ? '0 : dirty_q) | wr_mask;
      pending_d = (pending_q & ~clr_mask) | (commit ? dirty_q : '0);
      overrun_d = commit && (pending_q != '0);

      if (sid_reset_req) begin
         state_d   = ST_RESET;
         cnt_d     = '0;
         cs_n_d    = 1'b1;
         rw_d      = 1'b1;
         oe_d      = 1'b0;
         srst_n_d  = 1'b0;
         dirty_d   = '0;
         pending_d = '0;
         overrun_d = 1'b0;
      end

      busy_d = (state_d == ST_RESET) || (pending_d != '0);
   end

   // State and registered outputs; rst_n forces the safe bus state immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RESET;
         sid_clk_q <= 1'b0;
         cnt_q     <= '0;
         dirty_q   <= '0;
         pending_q <= '0;
         rd_addr_q <= '0;
         cs_n_q    <= 1'b1;
         rw_q      <= 1'b1;
         srst_n_q  <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sid_clk_q <= sid_clk;
         cnt_q     <= cnt_d;
         dirty_q   <= dirty_d;
         pending_q <= pending_d;
         rd_addr_q <= rd_addr_d;
         cs_n_q    <= cs_n_d;
         rw_q      <= rw_d;
         srst_n_q  <= srst_n_d;
         oe_q      <= oe_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign bus_oe    = oe_q;
   assign sid_cs_n  = cs_n_q;
   assign sid_rw    = rw_q;
   assign sid_rst_n = srst_n_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_sid_write_sched.sv
// tb/tb_sid_write_sched.sv - directed self-checking bench for sid_write_sched
module tb_sid_write_sched;

   logic       clk;
   logic       rst_n;
   logic       sid_clk;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic       commit;
   logic       sid_reset_req;
   logic [4:0] rd_addr;
   logic       bus_oe;
   logic       sid_cs_n;
   logic       sid_rw;
   logic       sid_rst_n;
   logic       busy;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   logic [4:0] sq[$];
   int         mon_err = 0;
   int         ov_cnt  = 0;
   logic       mon_cs_prev = 1'b1;
   logic       mon_sclk_prev = 1'b0;
   logic       mon_fall = 1'b0;

   typedef struct {
      int addr;
      int exp_n;
      int exp_addr;
      int exp_busy;
   } vec_t;

   vec_t vecs[6];

   sid_write_sched dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sid_clk       (sid_clk),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .commit        (commit),
      .sid_reset_req (sid_reset_req),
      .rd_addr       (rd_addr),
      .bus_oe        (bus_oe),
      .sid_cs_n      (sid_cs_n),
      .sid_rw        (sid_rw),
      .sid_rst_n     (sid_rst_n),
      .busy          (busy),
      .overrun       (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #25 clk = ~clk;
   end

   // 1 MHz phi2, toggled just after a clk edge so it stays synchronous to clk.
   initial begin
      sid_clk = 1'b0;
      forever begin
         repeat (10) @(posedge clk);
         #2 sid_clk = ~sid_clk;
      end
   end

   // Strobe monitor: logs addresses written and checks each strobe's shape.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mon_cs_prev && !sid_cs_n) begin
            sq.push_back(rd_addr);
            mon_fall = 1'b0;
         end
         if (!sid_cs_n) begin
            if (sid_rw !== 1'b0 || bus_oe !== 1'b1) mon_err++;
            if (sq.size() > 0 && rd_addr !== sq[sq.size()-1]) mon_err++;
            if (mon_sclk_prev && !sid_clk) mon_fall = 1'b1;
         end
         if (!mon_cs_prev && sid_cs_n && !mon_fall && sid_rst_n) mon_err++;
         if (overrun) ov_cnt++;
      end
      mon_cs_prev   = sid_cs_n;
      mon_sclk_prev = sid_clk;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic wr(input int a);
      wr_en   = 1'b1;
      wr_addr = 5'(a);
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   task automatic commit_pulse();
      commit = 1'b1;
      @(posedge clk); #1;
      commit = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle_timeout"}, int'(busy), 0);
   endtask

   // Counts phi2 falls while sid_rst_n is low, and any cs_n activity during that time.
   task automatic count_rst(output int falls, output int cs_lo);
      logic prev;
      int   n = 0;
      prev  = sid_clk;
      falls = 0;
      cs_lo = 0;
      @(negedge clk);
      while (!sid_rst_n && n < 600) begin
         if (prev && !sid_clk) falls++;
         if (!sid_cs_n) cs_lo++;
         prev = sid_clk;
         @(negedge clk);
         n++;
      end
      check("rst_release_timeout", int'(sid_rst_n), 1);
   endtask

   initial begin
      int falls;
      int cs_lo;
      int n;
      int busy_seen;
      int got;
      int exp_seq[$];

      vecs[0] = '{addr: 'h00, exp_n: 1, exp_addr: 'h00, exp_busy: 1};
      vecs[1] = '{addr: 'h18, exp_n: 1, exp_addr: 'h18, exp_busy: 1};
      vecs[2] = '{addr: 'h19, exp_n: 0, exp_addr: 0,     exp_busy: 0};
      vecs[3] = '{addr: 'h1A, exp_n: 0, exp_addr: 0,     exp_busy: 0};
      vecs[4] = '{addr: 'h1F, exp_n: 0, exp_addr: 0,     exp_busy: 0};
      vecs[5] = '{addr: 'h0C, exp_n: 1, exp_addr: 'h0C, exp_busy: 1};

      rst_n = 1'b0;
      wr_en = 1'b0;
      wr_addr = '0;
      commit = 1'b0;
      sid_reset_req = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_cs_n", int'(sid_cs_n), 1);
      check("rst_rw", int'(sid_rw), 1);
      check("rst_sid_rst_n", int'(sid_rst_n), 0);
      check("rst_rd_addr", int'(rd_addr), 0);
      check("rst_bus_oe", int'(bus_oe), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_overrun", int'(overrun), 0);

      // Power-up reset sequence
      rst_n = 1'b1;
      count_rst(falls, cs_lo);
      check("pwr_falls", falls, 10);
      check("pwr_cs_low", cs_lo, 0);
      check("pwr_busy", int'(busy), 0);
      check("pwr_strobes", sq.size(), 0);

      // Three registers, sent lowest address first
      @(posedge clk); #1;
      wr('h04);
      wr('h01);
      wr('h18);
      commit_pulse();
      wait_idle(400, "three");
      repeat (4) @(negedge clk);
      check("three_n", sq.size(), 3);
      got = (sq.size() > 0) ? int'(sq[0]) : -1;
      check("three_0", got, 'h01);
      got = (sq.size() > 1) ? int'(sq[1]) : -1;
      check("three_1", got, 'h04);
      got = (sq.size() > 2) ? int'(sq[2]) : -1;
      check("three_2", got, 'h18);
      check("three_bus_oe", int'(bus_oe), 0);

      // Single-write vectors, including the address range boundary
      for (int v = 0; v < 6; v++) begin
         sq.delete();
         @(posedge clk); #1;
         wr(vecs[v].addr);
         commit_pulse();
         busy_seen = 0;
         repeat (80) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
         end
         check($sformatf("vec%0d_n", v), sq.size(), vecs[v].exp_n);
         check($sformatf("vec%0d_busy", v), busy_seen, vecs[v].exp_busy);
         if (vecs[v].exp_n > 0) begin
            got = (sq.size() > 0) ? int'(sq[0]) : -1;
            check($sformatf("vec%0d_addr", v), got, vecs[v].exp_addr);
         end
      end

      // Full frame, second commit lands while the first is still streaming
      sq.delete();
      ov_cnt = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 25; i++) wr(i);
      commit_pulse();
      n = 0;
      while (sq.size() < 5 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("ovr_first5", (sq.size() >= 5) ? 1 : 0, 1);
      check("ovr_none_yet", ov_cnt, 0);
      @(posedge clk); #1;
      wr('h02);
      commit_pulse();
      wait_idle(1500, "ovr");
      repeat (4) @(negedge clk);
      check("ovr_pulses", ov_cnt, 1);
      for (int i = 0; i < 5; i++) exp_seq.push_back(i);
      exp_seq.push_back(2);
      for (int i = 5; i < 25; i++) exp_seq.push_back(i);
      check("ovr_n", sq.size(), exp_seq.size());
      n = 0;
      for (int i = 0; i < exp_seq.size(); i++) begin
         got = (i < sq.size()) ? int'(sq[i]) : -1;
         if (got != exp_seq[i]) n++;
      end
      check("ovr_order_errs", n, 0);

      // Reset request in the middle of a strobe
      sq.delete();
      @(posedge clk); #1;
      wr('h03);
      wr('h05);
      commit_pulse();
      n = 0;
      @(negedge clk);
      while (sid_cs_n && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rr_strobe_seen", int'(sid_cs_n), 0);
      @(posedge clk); #1;
      sid_reset_req = 1'b1;
      @(posedge clk); #1;
      sid_reset_req = 1'b0;
      check("rr_cs_n", int'(sid_cs_n), 1);
      check("rr_rst_n", int'(sid_rst_n), 0);
      check("rr_bus_oe", int'(bus_oe), 0);
      check("rr_busy", int'(busy), 1);
      count_rst(falls, cs_lo);
      check("rr_falls", falls, 10);
      check("rr_cs_low", cs_lo, 0);
      repeat (100) @(negedge clk);
      check("rr_n", sq.size(), 1);
      got = (sq.size() > 0) ? int'(sq[0]) : -1;
      check("rr_addr", got, 'h03);
      check("rr_idle", int'(busy), 0);

      // Write in the same clk as commit belongs to the next frame
      sq.delete();
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_addr = 5'h07;
      commit  = 1'b1;
      @(posedge clk); #1;
      wr_en   = 1'b0;
      commit  = 1'b0;
      busy_seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (busy) busy_seen = 1;
      end
      check("same_n", sq.size(), 0);
      check("same_busy", busy_seen, 0);
      @(posedge clk); #1;
      commit_pulse();
      wait_idle(400, "same");
      repeat (4) @(negedge clk);
      check("same_next_n", sq.size(), 1);
      got = (sq.size() > 0) ? int'(sq[0]) : -1;
      check("same_next_addr", got, 'h07);

      check("strobe_shape_errs", mon_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sid_write_sched.md
# sid_write_sched

Write scheduler between the SPI register RAM and the SID bus. Tracks which SID registers the SPI slave has modified, latches that set on each frame commit, then streams only changed registers to the SID, one write per sid_clk period, aligned to phi2. Also sequences the SID hardware reset at power-up and on request. Sits beside the RAM, drives its read port and the SID control lines.

## Interface
- NUM_REGS, 25, writable SID registers (addresses 0..NUM_REGS-1; higher addresses ignored)
- ADDR_BITS, 5, RAM/SID address width
- RST_CYCLES, 10, sid_clk periods sid_rst_n is held low
- clk  in  1  20 MHz system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- sid_clk  in  1  1 MHz phi2 level from the clock divider, synchronous to clk
- wr_en  in  1  SPI slave RAM write strobe (one clk)
- wr_addr  in  ADDR_BITS  address of that RAM write
- commit  in  1  frame-complete pulse (SPI data ready)
- sid_reset_req  in  1  pulse: abort and re-reset the SID
- rd_addr  out  ADDR_BITS  RAM read address; also the SID address bus value
- bus_oe  out  1  high while top level must drive SID addr/data
- sid_cs_n  out  1  SID chip select, active low
- sid_rw  out  1  SID read/write, low = write
- sid_rst_n  out  1  SID reset, active low
- busy  out  1  high in RESET or while pending set is non-empty
- overrun  out  1  one-clk pulse: commit arrived while previous frame unfinished

## Operation
- Edge detect: sid_clk registered to sid_clk_q; rise = sid_clk & ~sid_clk_q; fall = ~sid_clk & sid_clk_q.
- dirty[NUM_REGS]: set bit wr_addr on wr_en when wr_addr < NUM_REGS.
- commit: pending |= dirty; dirty cleared. A wr_en in the same clk sets its bit in the new dirty (next frame). If pending != 0 at commit, pulse overrun; sets merge, nothing is dropped.
- States: RESET, IDLE, ALIGN, STROBE.
- RESET: sid_rst_n=0, cs_n=1, rw=1, bus_oe=0; counts fall events; after RST_CYCLES falls, sid_rst_n=1, goto IDLE. dirty/pending cleared on entry.
- IDLE: if pending != 0, rd_addr <= lowest set index, goto ALIGN.
- ALIGN: bus_oe=1, rw=0, cs_n=1; on rise, cs_n<=0, goto STROBE.
- STROBE: cs_n=0, rw=0; on fall, cs_n<=1, rw<=1, clear pending[rd_addr], goto IDLE.
- Data on the SID bus is RAM content at strobe time; a re-write of a pending register before its strobe sends the newer value once.
- sid_reset_req (any state): cs_n<=1, rw<=1, bus_oe<=0, clear dirty, pending, counter; goto RESET next clk.

## Timing
- Reset values: sid_cs_n=1, sid_rw=1, sid_rst_n=0, rd_addr=0, bus_oe=0, busy=1, overrun=0, state RESET.
- All outputs registered; no combinational path input->output.
- RAM read latency 1 clk; rd_addr is stable ≥9 clk before cs_n falls.
- cs_n falls 1 clk after phi2 rises and rises 1 clk after phi2 falls: covers the SID latch edge with 50 ns hold.
- Throughput: one register per sid_clk period; full frame of 25 registers ≤ 26 µs after commit.
- rst_n assertion mid-write: outputs go to reset values immediately (async).

## Structure
- Package sid_pkg: NUM_REGS, RST_CYCLES, ADDR_BITS defaults, state enum (RESET, IDLE, ALIGN, STROBE).
- Sub-module sid_prio_enc: combinational lowest-set-bit encoder over pending, outputs index + valid.
- Remainder (edge detect, dirty/pending regs, FSM, reset counter) in sid_write_sched.

## Test plan
- Power-up: release rst_n -> sid_rst_n low for exactly 10 sid_clk falls, then high; cs_n never low; busy drops.
- Write addr 0x04, 0x01, 0x18 then commit -> three strobes in order 0x01, 0x04, 0x18, each cs_n low spanning one phi2 falling edge, rw low with cs_n.
- wr_en to 0x1A then commit -> no strobe, busy stays low.
- commit of 25 registers, second commit (addr 0x02 dirty) after 5 writes -> overrun pulse one clk, 0x02 written once more in order, no loss.
- sid_reset_req during STROBE -> cs_n high next clk, pending cleared, 10-cycle reset replays, no further writes.
- wr_en 0x07 in same clk as commit -> 0x07 not written until the next commit.
